// File: rtl/mem_access_sequencer.sv
// Byte-serial load/store sequencer between a core request port and a byte-wide memory.
// Optional build macro MISALIGN_CHECK_EN rejects misaligned half and word accesses.
module mem_access_sequencer #(
    parameter int unsigned MEM_BYTES = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_cs_o,
    output logic [31:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    output logic        mem_we_o,
    output logic        mem_re_o,
    input  logic [7:0]  mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    function automatic logic [1:0] last_idx(input logic [1:0] size);
        logic [1:0] idx;
        case (size)
            2'b00:   idx = 2'd0;
            2'b01:   idx = 2'd1;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // End address is formed in 33 bits so requests near 2^32 cannot wrap into range.
    function automatic logic req_error(input logic [1:0] size, input logic [31:0] addr);
        logic [32:0] end_addr;
        logic        err;
        end_addr = {1'b0, addr} + {31'd0, last_idx(size)};
        err      = (size == 2'b11) || (end_addr >= 33'(MEM_BYTES));
`ifdef MISALIGN_CHECK_EN
        err      = err || ((size == 2'b01) && addr[0]) ||
                   ((size == 2'b10) && (addr[1:0] != 2'b00));
`endif
        return err;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic uns);
        logic [31:0] res;
        case (size)
            2'b00:   res = {{24{~uns & raw[7]}}, raw[7:0]};
            2'b01:   res = {{16{~uns & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] hold_q, hold_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        mem_cs_q, mem_cs_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_re_q, mem_re_d;
    logic [1:0]  next_cnt_s;
    logic [31:0] merged_s;

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        hold_d       = hold_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        mem_cs_d     = 1'b0;
        mem_addr_d   = 32'd0;
        mem_wdata_d  = 8'd0;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        next_cnt_s   = cnt_q + 2'd1;
        merged_s     = hold_q;
        merged_s[{cnt_q, 3'b000} +: 8] = mem_rdata_i;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    write_d = req_write_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    cnt_d   = 2'd0;
                    if (req_error(req_size_i, req_addr_i)) begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        mem_cs_d    = 1'b1;
                        mem_addr_d  = req_addr_i;
                        mem_we_d    = req_write_i;
                        mem_re_d    = ~req_write_i;
                        mem_wdata_d = req_write_i ? req_wdata_i[7:0] : 8'd0;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ACCESS: begin
                if (!write_q) begin
                    hold_d = merged_s;
                end else begin
                    hold_d = hold_q;
                end
                if (cnt_q == last_idx(size_q)) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = write_q ? 32'd0 : extend(merged_s, size_q, uns_q);
                end else begin
                    cnt_d       = next_cnt_s;
                    mem_cs_d    = 1'b1;
                    mem_addr_d  = addr_q + {30'd0, next_cnt_s};
                    mem_we_d    = write_q;
                    mem_re_d    = ~write_q;
                    mem_wdata_d = write_q ? wdata_q[{next_cnt_s, 3'b000} +: 8] : 8'd0;
                end
            end
            DONE: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            write_q      <= 1'b0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            hold_q       <= 32'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            mem_cs_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 8'd0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            hold_q       <= hold_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_cs_q     <= mem_cs_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
        end
    end

    // Strobes drop as soon as reset is seen so an aborted store writes no further byte.
    assign mem_cs_o     = mem_cs_q & ~reset;
    assign mem_we_o     = mem_we_q & ~reset;
    assign mem_re_o     = mem_re_q & ~reset;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Testbench for mem_access_sequencer: directed vector table, reset corner cases,
// and randomized requests checked against a byte-array reference model.
module tb_mem_access_sequencer;

    localparam int MEMB = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_cs, mem_we, mem_re;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0]  mem     [0:MEMB-1];
    logic [7:0]  ref_mem [0:MEMB-1];
    int          n_cmp = 0;
    int          n_mis = 0;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
    } vec_t;
    vec_t tbl[16];

    mem_access_sequencer #(.MEM_BYTES(MEMB)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
        .resp_err_o(resp_err), .mem_cs_o(mem_cs), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_re_o(mem_re),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte memory: combinational read, write on rising edge.
    assign mem_rdata = (mem_re && mem_addr < 32'(MEMB)) ? mem[mem_addr[8:0]] : 8'h00;
    always @(posedge clk) begin
        if (mem_we && mem_addr < 32'(MEMB)) mem[mem_addr[8:0]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic setb(input int a, input logic [7:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // Reference: expected error and load data from the access rules, using plain arithmetic.
    function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                  input logic [31:0] a, output logic err, output logic [31:0] rd);
        longint unsigned val;
        longint unsigned last;
        int n;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        last = longint'({32'd0, a}) + longint'(n - 1);
        err  = (sz == 2'd3) || (last >= longint'(MEMB));
`ifdef MISALIGN_CHECK_EN
        if ((n == 2 && a % 2 != 0) || (n == 4 && a % 4 != 0)) err = 1'b1;
`endif
        rd = 32'd0;
        if (!err && !w) begin
            val = 0;
            for (int k = 0; k < n; k++) val += longint'(ref_mem[a + 32'(k)]) << (8 * k);
            if (!u && val >= (64'd1 << (8 * n - 1))) val = val + (64'd1 << 32) - (64'd1 << (8 * n));
            rd = 32'(val);
        end
    endfunction

    task automatic run_req(input string nm, input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic exp_err, input logic [31:0] exp_rd);
        int n;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        @(negedge clk);
        chk({nm, " ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        if (!exp_err) begin
            for (int j = 0; j < n; j++) begin
                @(negedge clk);
                chk({nm, " cs"}, 32'(mem_cs), 32'd1);
                chk({nm, " addr"}, mem_addr, a + 32'(j));
                chk({nm, " we"}, 32'(mem_we), 32'(w));
                chk({nm, " re"}, 32'(mem_re), 32'(!w));
                chk({nm, " wdata"}, 32'(mem_wdata), w ? 32'(wd[8*j +: 8]) : 32'd0);
                chk({nm, " valid_early"}, 32'(resp_valid), 32'd0);
                chk({nm, " ready_busy"}, 32'(req_ready), 32'd0);
            end
            if (w) for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = wd[8*k +: 8];
        end
        @(negedge clk);
        chk({nm, " valid"}, 32'(resp_valid), 32'd1);
        chk({nm, " err"}, 32'(resp_err), 32'(exp_err));
        chk({nm, " rdata"}, resp_rdata, exp_rd);
        chk({nm, " cs_done"}, 32'(mem_cs | mem_we | mem_re), 32'd0);
        chk({nm, " ready_done"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        chk({nm, " valid_after"}, {30'd0, resp_valid, resp_err}, 32'd0);
        chk({nm, " rdata_after"}, resp_rdata, 32'd0);
        chk({nm, " ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic        e;
        logic [31:0] r, a;
        logic [1:0]  sz;
        logic        w, u;

        for (int i = 0; i < MEMB; i++) setb(i, 8'(i * 37 + 11));
        setb(32'h020, 8'h80); setb(32'h021, 8'hFF);
        setb(5, 8'h11); setb(6, 8'h22); setb(7, 8'h33); setb(8, 8'h44);
        setb(32'h1FF, 8'h5A);
        for (int i = 32'h40; i < 32'h44; i++) setb(i, 8'h00);

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 2'd2, 1'b1, 32'h010, 32'h0, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 2'd1, 1'b0, 32'h020, 32'h0, 1'b0, 32'hFFFFFF80};
        tbl[3]  = '{1'b0, 2'd1, 1'b1, 32'h020, 32'h0, 1'b0, 32'h0000FF80};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h021, 32'h0, 1'b0, 32'h000000FF};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 32'h021, 32'h0, 1'b0, 32'hFFFFFFFF};
        tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h1FE, 32'h0, 1'b1, 32'h0};
`ifdef MISALIGN_CHECK_EN
        tbl[7]  = '{1'b0, 2'd2, 1'b1, 32'h005, 32'h0, 1'b1, 32'h0};
`else
        tbl[7]  = '{1'b0, 2'd2, 1'b1, 32'h005, 32'h0, 1'b0, 32'h44332211};
`endif
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 32'h1FF, 32'h0, 1'b0, 32'h0000005A};
        tbl[9]  = '{1'b0, 2'd1, 1'b1, 32'h1FF, 32'h0, 1'b1, 32'h0};
        tbl[10] = '{1'b1, 2'd0, 1'b0, 32'h1FF, 32'h123456A5, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 2'd0, 1'b0, 32'h1FF, 32'h0, 1'b0, 32'hFFFFFFA5};
        tbl[12] = '{1'b0, 2'd0, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0};
        tbl[13] = '{1'b0, 2'd3, 1'b1, 32'h000, 32'h0, 1'b1, 32'h0};
        tbl[14] = '{1'b1, 2'd1, 1'b0, 32'h030, 32'hBEEF1234, 1'b0, 32'h0};
        tbl[15] = '{1'b0, 2'd1, 1'b1, 32'h030, 32'h0, 1'b0, 32'h00001234};

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst ready", 32'(req_ready), 32'd1);
        chk("rst resp", {29'd0, resp_valid, resp_err, mem_cs}, 32'd0);
        chk("rst rdata", resp_rdata, 32'd0);
        chk("rst strobes", {30'd0, mem_we, mem_re}, 32'd0);
        chk("rst addr", mem_addr, 32'd0);
        chk("rst wdata", 32'(mem_wdata), 32'd0);

        for (int i = 0; i < 16; i++)
            run_req($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a,
                    tbl[i].wd, tbl[i].err, tbl[i].rd);

        // Reset in the second cycle of a word store: only the first byte lands.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h040; req_wdata = 32'h11223344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort we0", {31'd0, mem_we}, 32'd1);
        chk("abort addr0", mem_addr, 32'h040);
        @(negedge clk);
        chk("abort addr1", mem_addr, 32'h041);
        reset = 1'b1;
        #1 chk("abort we_gated", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("abort ready", 32'(req_ready), 32'd1);
        chk("abort cs", 32'(mem_cs), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort no_resp", {30'd0, resp_valid, mem_we}, 32'd0);
        end
        chk("abort mem40", 32'(mem[32'h40]), 32'h44);
        chk("abort mem41", 32'(mem[32'h41]), 32'h00);
        chk("abort mem42", 32'(mem[32'h42]), 32'h00);
        ref_mem[32'h40] = 8'h44;

        // Reset coinciding with a request: the request is dropped.
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_size = 2'd0; req_addr = 32'h10;
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        chk("rstreq ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstreq idle", {30'd0, resp_valid, mem_cs}, 32'd0);
        end

        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(500, 520))
                                             : 32'($urandom_range(0, 511));
            model(w, sz, u, a, e, r);
            run_req($sformatf("rnd%0d", i), w, sz, u, a, $urandom, e, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
